// File: rtl/tb_status_periph.sv
// Test-status and stdout responder on the core data bus.
// It decodes stores that print a character, report pass/fail or report an
// exit code. It also exposes a free-running cycle counter and the occupancy
// of the character FIFO as read-only registers.
module tb_status_periph #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        char_valid_o,
   output logic [7:0]  char_o,
   input  logic        char_ready_i,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   localparam logic [2:0] OFF_PRINT = 3'd0;
   localparam logic [2:0] OFF_EXIT  = 3'd1;
   localparam logic [2:0] OFF_TEST  = 3'd2;
   localparam logic [2:0] OFF_CYCLE = 3'd3;
   localparam logic [2:0] OFF_LEVEL = 3'd4;

   // Character FIFO storage and bookkeeping
   logic [7:0]       r_fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;

   // Bus response
   logic             r_rvalid;
   logic [31:0]      r_rdata;

   // Status registers
   logic             r_passed;
   logic             r_failed;
   logic             r_exit_valid;
   logic [31:0]      r_exit_value;
   logic [31:0]      r_cycle;

   // Decode and handshake wires
   logic [2:0]       w_offset;
   logic             w_print_wr;
   logic             w_full;
   logic             w_gnt;
   logic             w_wr_gnt;
   logic             w_push;
   logic             w_pop;
   logic [31:0]      w_rd_value;
   logic             w_unused;

   assign w_offset   = data_addr_i[4:2];
   assign w_print_wr = data_we_i && (w_offset == OFF_PRINT) && data_be_i[0];
   // Full comes straight from the registered level, so a pop in the same
   // cycle cannot rescue a stalled push; the slot opens on the next cycle.
   assign w_full     = (r_level == LVL_FULL);
   assign w_gnt      = data_req_i && !(w_print_wr && w_full);
   assign w_wr_gnt   = w_gnt && data_we_i;
   assign w_push     = w_gnt && w_print_wr;
   assign w_pop      = char_valid_o && char_ready_i;

   assign data_gnt_o     = w_gnt;
   assign data_rvalid_o  = r_rvalid;
   assign data_rdata_o   = r_rdata;
   assign char_valid_o   = (r_level != '0);
   assign char_o         = r_fifo_mem[r_rd_ptr];
   assign tests_passed_o = r_passed;
   assign tests_failed_o = r_failed;
   assign exit_valid_o   = r_exit_valid;
   assign exit_value_o   = r_exit_value;

   // Only address bits [4:2] and byte lane 0 carry meaning here
   assign w_unused = ^{data_addr_i[31:5], data_addr_i[1:0], data_be_i[3:1]};

   // Read mux: value of the addressed register in the grant cycle
   always_comb begin
      w_rd_value = '0;
      case (w_offset)
         OFF_EXIT:  w_rd_value = r_exit_value;
         OFF_TEST:  w_rd_value = {30'd0, r_failed, r_passed};
         OFF_CYCLE: w_rd_value = r_cycle;
         OFF_LEVEL: w_rd_value = 32'(r_level);
         default:   w_rd_value = '0;
      endcase
   end

   // FIFO storage: cleared on reset so char_o is 0 out of reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= data_wdata_i[7:0];
      end
   end

   // FIFO pointers wrap naturally; the level counter separates full from empty
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
         end else if (!w_push && w_pop) begin
            r_level <= r_level - LVL_W'(1);
         end
      end
   end

   // One-cycle response to every grant; rdata is zero outside read responses
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_gnt;
         r_rdata  <= (w_gnt && !data_we_i) ? w_rd_value : '0;
      end
   end

   // Sticky status flags and exit code capture
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_passed     <= 1'b0;
         r_failed     <= 1'b0;
         r_exit_valid <= 1'b0;
         r_exit_value <= '0;
      end else if (w_wr_gnt) begin
         if (w_offset == OFF_EXIT) begin
            r_exit_valid <= 1'b1;
            r_exit_value <= data_wdata_i;
         end
         if (w_offset == OFF_TEST) begin
            if (data_wdata_i == PASS_MAGIC) begin
               r_passed <= 1'b1;
            end else begin
               r_failed <= 1'b1;
            end
         end
      end
   end

   // Free-running cycle counter, wraps through zero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cycle <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

endmodule

// File: tb/tb_tb_status_periph.sv
// Bench for tb_status_periph: randomized and directed bus traffic checked
// against a queue-based behavioural model through a response scoreboard.
`timescale 1ns/1ps
module tb_tb_status_periph;

   localparam int          DEPTH = 8;
   localparam logic [31:0] MAGIC = 32'd123456789;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        data_req_i = 1'b0;
   logic        data_gnt_o;
   logic [31:0] data_addr_i = '0;
   logic        data_we_i = 1'b0;
   logic [3:0]  data_be_i = '0;
   logic [31:0] data_wdata_i = '0;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        char_valid_o;
   logic [7:0]  char_o;
   logic        char_ready_i = 1'b0;
   logic        tests_passed_o;
   logic        tests_failed_o;
   logic        exit_valid_o;
   logic [31:0] exit_value_o;

   tb_status_periph #(.FIFO_DEPTH(DEPTH), .PASS_MAGIC(MAGIC)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .data_req_i    (data_req_i),
      .data_gnt_o    (data_gnt_o),
      .data_addr_i   (data_addr_i),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_wdata_i  (data_wdata_i),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .char_valid_o  (char_valid_o),
      .char_o        (char_o),
      .char_ready_i  (char_ready_i),
      .tests_passed_o(tests_passed_o),
      .tests_failed_o(tests_failed_o),
      .exit_valid_o  (exit_valid_o),
      .exit_value_o  (exit_value_o)
   );

   always #5 clk_i = ~clk_i;

   // Scoreboard of expected responses
   typedef struct {
      int          due;
      logic [31:0] rdata;
   } rsp_t;
   rsp_t sb_q[$];

   // Behavioural model state
   logic [7:0]  m_fifo[$];
   logic        m_passed, m_failed, m_exit_valid;
   logic [31:0] m_exit_value, m_cyc;
   logic        pend_valid;
   logic [2:0]  pend_off;
   logic [3:0]  pend_be;
   logic [31:0] pend_wdata;

   int tb_cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   int ready_mode = 0;   // 0 low, 1 high, 2 random
   int pulse_at = -1;    // wait index at which ready pulses high

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] off);
      case (off)
         3'd1:    return m_exit_value;
         3'd2:    return {30'd0, m_failed, m_passed};
         3'd3:    return m_cyc;
         3'd4:    return 32'(m_fifo.size());
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_clear();
      m_fifo.delete();
      sb_q.delete();
      m_passed = 0; m_failed = 0; m_exit_valid = 0;
      m_exit_value = 0; m_cyc = 0; pend_valid = 0;
   endtask

   task automatic drive_ready(input int w);
      if (ready_mode == 2) char_ready_i = 1'($urandom_range(0, 1));
      else char_ready_i = (ready_mode == 1) || (w == pulse_at);
   endtask

   // One bus transaction: hold the request until the model says it is granted
   task automatic bus(input logic we, input logic [2:0] off, input logic [3:0] be,
                      input logic [31:0] wdata, output int waited);
      logic [31:0] rnd;
      logic        exp_gnt;
      rsp_t        rsp;
      int          w;
      w = 0;
      rnd = $urandom;
      forever begin
         @(negedge clk_i);
         data_req_i   = 1'b1;
         data_we_i    = we;
         data_be_i    = be;
         data_wdata_i = wdata;
         data_addr_i  = {rnd[31:5], off, rnd[1:0]};
         drive_ready(w);
         #1;
         exp_gnt = !(we && off == 3'd0 && be[0] && m_fifo.size() == DEPTH);
         check("gnt", data_gnt_o, exp_gnt);
         if (exp_gnt) break;
         w++;
         if (w > 300) begin
            check("gnt_timeout", 32'(w), 32'd0);
            break;
         end
      end
      rsp.due   = tb_cyc + 1;
      rsp.rdata = we ? 32'd0 : model_read(off);
      sb_q.push_back(rsp);
      if (we) begin
         pend_valid = 1; pend_off = off; pend_be = be; pend_wdata = wdata;
      end
      $display("txn %s off=%0d be=%h wdata=%08h exp_rdata=%08h waited=%0d",
               we ? "WR" : "RD", off, be, wdata, rsp.rdata, w);
      waited = w;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_i);
         data_req_i = 1'b0;
         data_we_i  = 1'b0;
         drive_ready(-2);
      end
   endtask

   // Asynchronous reset: outputs must clear before any clock edge
   task automatic apply_reset();
      #2;
      data_req_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      check("rst_rvalid", data_rvalid_o, 0);
      check("rst_rdata", data_rdata_o, 0);
      check("rst_char_valid", char_valid_o, 0);
      check("rst_char", char_o, 0);
      check("rst_passed", tests_passed_o, 0);
      check("rst_failed", tests_failed_o, 0);
      check("rst_exit_valid", exit_valid_o, 0);
      check("rst_exit_value", exit_value_o, 0);
      model_clear();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   // Monitor and model commit, once per cycle after inputs have settled
   always @(negedge clk_i) begin
      logic        exp_rv;
      logic [31:0] exp_rd;
      rsp_t        rsp;
      #2;
      if (rst_ni) begin
         exp_rv = (sb_q.size() != 0) && (sb_q[0].due == tb_cyc);
         exp_rd = 32'd0;
         if (exp_rv) begin
            rsp = sb_q.pop_front();
            exp_rd = rsp.rdata;
         end
         check("rvalid", data_rvalid_o, exp_rv);
         check("rdata", data_rdata_o, exp_rd);
         check("passed", tests_passed_o, m_passed);
         check("failed", tests_failed_o, m_failed);
         check("exit_valid", exit_valid_o, m_exit_valid);
         check("exit_value", exit_value_o, m_exit_value);
         check("char_valid", char_valid_o, m_fifo.size() != 0);
         if (m_fifo.size() != 0) begin
            check("char", char_o, m_fifo[0]);
            if (char_ready_i) void'(m_fifo.pop_front());
         end
         if (pend_valid) begin
            case (pend_off)
               3'd0: if (pend_be[0]) m_fifo.push_back(pend_wdata[7:0]);
               3'd1: begin m_exit_valid = 1; m_exit_value = pend_wdata; end
               3'd2: if (pend_wdata == MAGIC) m_passed = 1; else m_failed = 1;
               default: ;
            endcase
            pend_valid = 0;
         end
         m_cyc = m_cyc + 32'd1;
      end
      tb_cyc++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      logic [2:0]  off;
      logic [31:0] wd;
      model_clear();
      #1;
      apply_reset();

      // Print stream with an always-ready sink
      ready_mode = 1;
      bus(1, 3'd0, 4'h1, 32'h0000_0048, w);
      bus(1, 3'd0, 4'h1, 32'hABCD_1269, w);
      bus(1, 3'd0, 4'h1, 32'h0000_000A, w);
      idle(3);
      bus(0, 3'd4, 4'hF, 32'h0, w);
      bus(1, 3'd0, 4'h0, 32'h0000_0055, w);  // be[0] clear: no push
      idle(2);

      // Backpressure: fill, stall the ninth, release one slot for one cycle
      ready_mode = 0;
      for (int i = 0; i < 8; i++) bus(1, 3'd0, 4'h1, 32'h30 + 32'(i), w);
      bus(0, 3'd4, 4'hF, 32'h0, w);
      pulse_at = 1;
      bus(1, 3'd0, 4'h1, 32'h0000_0039, w);
      pulse_at = -1;
      check("stall_cycles", 32'(w), 32'd2);
      ready_mode = 1;
      idle(12);

      // Pass, then fail after reset
      bus(1, 3'd2, 4'hF, MAGIC, w);
      bus(0, 3'd2, 4'hF, 32'h0, w);
      apply_reset();
      bus(1, 3'd2, 4'hF, 32'h5, w);
      bus(0, 3'd2, 4'hF, 32'h0, w);

      // Exit code capture and overwrite
      bus(1, 3'd1, 4'h0, 32'h0, w);
      bus(0, 3'd1, 4'hF, 32'h0, w);
      bus(1, 3'd1, 4'h3, 32'h2A, w);
      bus(0, 3'd1, 4'hF, 32'h0, w);

      // Cycle counter wrap, unmapped offsets, ignored CYCLE write
      @(negedge clk_i);
      data_req_i = 1'b0;
      force dut.r_cycle = 32'hFFFF_FFFE;
      m_cyc = 32'hFFFF_FFFE;
      #1;
      release dut.r_cycle;
      repeat (3) bus(0, 3'd3, 4'hF, 32'h0, w);
      for (int o = 5; o < 8; o++) bus(0, 3'(o), 4'hF, 32'h0, w);
      bus(1, 3'd3, 4'hF, 32'h0, w);
      bus(0, 3'd3, 4'hF, 32'h0, w);
      bus(1, 3'd4, 4'hF, 32'h0, w);
      bus(0, 3'd4, 4'hF, 32'h0, w);

      // Randomized traffic with a random sink
      ready_mode = 2;
      for (int t = 0; t < 250; t++) begin
         off = 3'($urandom_range(0, 7));
         wd  = $urandom;
         if (off == 3'd2 && $urandom_range(0, 1) == 1) wd = MAGIC;
         bus(1'($urandom_range(0, 1)), off, 4'($urandom_range(0, 15)), wd, w);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      ready_mode = 1;
      idle(12);

      // Async reset mid-burst with three bytes queued and flags set
      ready_mode = 0;
      apply_reset();
      bus(1, 3'd2, 4'hF, MAGIC, w);
      bus(1, 3'd1, 4'hF, 32'h7, w);
      bus(1, 3'd0, 4'h1, 32'h61, w);
      bus(1, 3'd0, 4'h1, 32'h62, w);
      bus(1, 3'd0, 4'h1, 32'h63, w);
      bus(0, 3'd4, 4'hF, 32'h0, w);
      apply_reset();
      idle(2);
      bus(0, 3'd4, 4'hF, 32'h0, w);
      bus(0, 3'd2, 4'hF, 32'h0, w);
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tb_status_periph.md
# tb_status_periph

Memory-mapped test-status and stdout responder inside the core testbench subsystem. It sits on the core data bus as an OBI-style responder and decodes stores that report a character, test pass/fail, or a program exit code. It drives the `tests_passed_o`, `tests_failed_o`, `exit_valid_o` and `exit_value_o` signals that the testbench top samples to end simulation. Characters are buffered in a small FIFO and streamed out on a valid/ready port to a print sink.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: character FIFO entries; must be a power of two, ≥2.
- `PASS_MAGIC`, default 32'd123456789: value written to TEST_STATUS that signals pass.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `data_req_i`  in  1  bus request. The subsystem has already routed the request to this block.
- `data_gnt_o`  out  1  grant, combinational.
- `data_addr_i`  in  32  byte address; only bits [4:2] are decoded.
- `data_we_i`  in  1  1 = write.
- `data_be_i`  in  4  byte enables.
- `data_wdata_i`  in  32  write data.
- `data_rvalid_o`  out  1  response valid, registered.
- `data_rdata_o`  out  32  read data, registered.
- `char_valid_o`  out  1  FIFO head valid.
- `char_o`  out  8  FIFO head byte.
- `char_ready_i`  in  1  sink accepts head.
- `tests_passed_o`  out  1  sticky pass flag.
- `tests_failed_o`  out  1  sticky fail flag.
- `exit_valid_o`  out  1  sticky exit flag.
- `exit_value_o`  out  32  captured exit code.

## Operation
Register map, decoded from `addr[4:2]`:
- 0 **PRINT**, W. If `be[0]` is set, push `wdata[7:0]` into the FIFO. If `be[0]` is clear, the access is granted with no push. Reads return 0.
- 1 **EXIT**, W. Set `exit_value_o` to `wdata` (byte enables ignored) and set `exit_valid_o`. Reads return `exit_value_o`.
- 2 **TEST_STATUS**, W. If `wdata == PASS_MAGIC`, set `tests_passed_o`. Any other value sets `tests_failed_o`. Reads return {30'b0, failed, passed}.
- 3 **CYCLE**, R. Free-running 32-bit counter, incremented every cycle after reset; wraps from 0xFFFF_FFFF to 0. Writes are ignored.
- 4 **FIFO_LEVEL**, R. Zero-extended occupancy, 0..FIFO_DEPTH. Writes are ignored.
- 5–7: reads return 0; writes are ignored.

Grant rule:
- `data_gnt_o = data_req_i && !(we && offset==0 && be[0] && fifo_full)`.
- Every other access is granted in the same cycle it is requested.

Flag behaviour:
- All flags are sticky until reset.
- A second EXIT write overwrites `exit_value_o`; `exit_valid_o` stays 1.
- Pass and fail may both become set.

FIFO behaviour:
- Push happens on a granted PRINT write. Pop happens on `char_valid_o && char_ready_i`.
- `char_valid_o = (level != 0)`. `char_o` is the head entry.
- Push and pop in the same cycle leave the level unchanged.
- When full, a pop frees a slot only for the next cycle. The push stalls that cycle because the grant is computed from the registered full flag.
- Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty is distinguished with an extra pointer bit or a level counter.

## Timing
- **Response:** `data_rvalid_o` is asserted exactly 1 cycle after each granted request, for both reads and writes, for one cycle. Back-to-back grants give back-to-back rvalid.
- **Read data:** `data_rdata_o` holds the read value in the rvalid cycle and 0 otherwise, including after write responses.
- **Flag latency:** `tests_*`, `exit_*`, and the EXIT/TEST_STATUS register values change on the clock edge that ends the grant cycle. They are visible in the rvalid cycle.
- **CYCLE reads:** return the counter value at the grant cycle.
- **FIFO latency:** `char_valid_o` rises 1 cycle after the grant of a push into an empty FIFO.
- **Reset values:** all outputs reset to 0: gnt is combinational, rvalid=0, rdata=0, char_valid=0, char_o=0 (the output is driven from reset-cleared storage), all flags 0, exit_value=0. CYCLE=0 and FIFO empty.
- **Reset mid-operation:** a pending rvalid is dropped, FIFO contents are discarded, and the flags clear immediately, asynchronously.

## Test plan
- **Print stream.** Write PRINT with 0x48, 0x69, 0x0A, `char_ready_i`=1. Required: each rvalid 1 cycle after its gnt; `char_o` sequence 0x48, 0x69, 0x0A, each valid 1 cycle after its grant; FIFO_LEVEL read returns 0 afterwards.
- **FIFO full backpressure.** With `char_ready_i`=0, do 9 PRINT writes and FIFO_DEPTH=8. Required: first 8 granted, FIFO_LEVEL=8, 9th request has `data_gnt_o`=0. Raise ready for one cycle: one pop, then the 9th is granted the following cycle. All 9 bytes come out in order.
- **Pass/fail.** Write TEST_STATUS with 123456789. Required: `tests_passed_o`=1 in the rvalid cycle and TEST_STATUS reads 0x1. After reset, write 0x5: `tests_failed_o`=1 and the read returns 0x2.
- **Exit.** Write EXIT with 0, then EXIT with 0x2A. Required: `exit_valid_o`=1 after the first write with value 0, then the value updates to 0x2A while valid stays 1.
- **Cycle wrap and decode.** Force CYCLE to 0xFFFF_FFFE, read twice back-to-back. Required: values differ by 1, and the counter passes through 0 without stalling. Read offsets 5–7: return 0. Write CYCLE: no effect.
- **Async reset.** Assert `rst_ni` low mid-burst, between grant and rvalid, with 3 bytes queued. Required: rvalid not issued, `char_valid_o`=0, all flags 0 immediately.
